// File: rtl/vga_pattern_scheduler_if.sv
// VGA pattern scheduler bus: raw switches and counters in, pattern select out.
// Ports: i_SW1..4, i_CountCol/Row (to slave); o_Pattern, o_Auto, o_Pending, o_Frame_Start (from slave).
interface vga_pattern_scheduler_if #(
  parameter int CNT_W = 10
);
  logic             i_SW1;
  logic             i_SW2;
  logic             i_SW3;
  logic             i_SW4;
  logic [CNT_W-1:0] i_CountCol;
  logic [CNT_W-1:0] i_CountRow;
  logic [1:0]       o_Pattern;
  logic             o_Auto;
  logic             o_Pending;
  logic             o_Frame_Start;

  modport master (
    output i_SW1, i_SW2, i_SW3, i_SW4,
    output i_CountCol, i_CountRow,
    input  o_Pattern, o_Auto, o_Pending, o_Frame_Start
  );

  modport slave (
    input  i_SW1, i_SW2, i_SW3, i_SW4,
    input  i_CountCol, i_CountRow,
    output o_Pattern, o_Auto, o_Pending, o_Frame_Start
  );
endinterface

// File: rtl/vga_pattern_scheduler.sv
// VGA pattern scheduler: switch conditioning, manual/auto mode, frame-aligned commit.
// Ports: CLK, i_RST_N (async low), vif (slave: switches, counters in; pattern, mode, frame pulse out).
module vga_pattern_scheduler #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FRAMES_PER_STEP = 60,
  parameter int CNT_W           = 10
) (
  input logic                    CLK,
  input logic                    i_RST_N,
  vga_pattern_scheduler_if.slave vif
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int FR_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FR_W-1:0]  FR_LAST = FR_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] ORIGIN  = '0;

  typedef enum logic [1:0] {
    MANUAL_IDLE,
    MANUAL_PENDING,
    AUTO
  } mode_e;

  logic [3:0]      w_raw;
  logic [3:0]      r_meta;
  logic [3:0]      r_sync;
  logic [3:0]      r_lvl;
  logic [DB_W-1:0] r_cnt [4];
  logic [3:0]      w_mis;
  logic [3:0]      w_flip;
  logic [3:0]      w_press;

  logic            w_col;
  logic [1:0]      w_code;
  logic            w_origin;

  mode_e           r_state;
  mode_e           w_nxt;
  logic [1:0]      r_pat;
  logic [1:0]      r_pend;
  logic [FR_W-1:0] r_fcnt;
  logic            r_fs;
  logic            r_auto;
  logic            r_pflag;

  assign w_raw = {vif.i_SW4, vif.i_SW3, vif.i_SW2, vif.i_SW1};
  assign w_mis = r_sync ^ r_lvl;

  // The level flips on the edge where the mismatch run completes;
  // a press is that flip when the new level is high.
  always_comb begin
    w_flip  = '0;
    w_press = '0;
    for (int i = 0; i < 4; i++) begin
      w_flip[i]  = w_mis[i] && (r_cnt[i] == DB_LAST);
      w_press[i] = w_flip[i] && r_sync[i];
    end
  end

  always_ff @(posedge CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_meta <= '0;
      r_sync <= '0;
      r_lvl  <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
      r_lvl  <= r_lvl ^ w_flip;
      for (int i = 0; i < 4; i++) begin
        if (!w_mis[i] || w_flip[i]) r_cnt[i] <= '0;
        else                        r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  // Same-cycle colour presses: lowest switch number wins.
  always_comb begin
    w_col  = |w_press[2:0];
    w_code = 2'd0;
    if (w_press[0])      w_code = 2'd1;
    else if (w_press[1]) w_code = 2'd2;
    else if (w_press[2]) w_code = 2'd3;
  end

  assign w_origin = (vif.i_CountCol == ORIGIN) &&
                    (vif.i_CountRow == ORIGIN);

  // Colour beats SW4; a commit only retires the pending state
  // when no new press arrives on the same edge.
  always_comb begin
    w_nxt = r_state;
    if (w_col) begin
      w_nxt = MANUAL_PENDING;
    end else if (w_press[3]) begin
      w_nxt = (r_state == AUTO) ? MANUAL_IDLE : AUTO;
    end else if (w_origin && r_state == MANUAL_PENDING) begin
      w_nxt = MANUAL_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state <= MANUAL_IDLE;
      r_pat   <= 2'd0;
      r_pend  <= 2'd0;
      r_fcnt  <= '0;
      r_fs    <= 1'b0;
      r_auto  <= 1'b0;
      r_pflag <= 1'b0;
    end else begin
      r_fs <= w_origin;
      // Commit acts on the mode held before this edge.
      if (w_origin) begin
        if (r_state == MANUAL_PENDING) begin
          r_pat <= r_pend;
        end else if (r_state == AUTO && !w_col && !w_press[3]) begin
          if (r_fcnt == FR_LAST) begin
            r_fcnt <= '0;
            r_pat  <= r_pat + 2'd1;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
      end
      if (w_col) begin
        r_pend <= w_code;
      end else if (w_press[3] && r_state != AUTO) begin
        r_pend <= 2'd0;
        r_fcnt <= '0;
      end
      r_state <= w_nxt;
      r_auto  <= (w_nxt == AUTO);
      r_pflag <= (w_nxt == MANUAL_PENDING);
    end
  end

  assign vif.o_Pattern     = r_pat;
  assign vif.o_Auto        = r_auto;
  assign vif.o_Pending     = r_pflag;
  assign vif.o_Frame_Start = r_fs;
endmodule
